// File: rtl/wb_queue.sv
// Register-writeback queue: FIFO of pending GRF writes from the pipeline and mult/div unit,
// one-cycle enqueue-to-issue latency; pipeline has priority, a full queue deasserts both readies.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic [31:0] p_pc,
  output logic        p_ready,
  input  logic        m_valid,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_wd,
  input  logic [31:0] m_pc,
  output logic        m_ready,
  input  logic        grf_busy,
  output logic        RegWrite,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic [31:0] PC,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic        pend1,
  output logic        pend2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    wa_q [DEPTH];
  logic [31:0]   wd_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] idx;
  logic          full;
  logic          p_fire;
  logic          m_fire;
  logic          enq;
  logic          deq;
  logic [4:0]    in_wa;
  logic [31:0]   in_wd;
  logic [31:0]   in_pc;

  assign full    = (count == CW'(DEPTH));
  assign p_ready = !full;
  assign m_ready = !full && !p_valid;
  assign p_fire  = p_valid && p_ready;
  assign m_fire  = m_valid && m_ready;

  assign in_wa = p_fire ? p_wa : m_wa;
  assign in_wd = p_fire ? p_wd : m_wd;
  assign in_pc = p_fire ? p_pc : m_pc;
  // Writes to $0 are accepted on the handshake but never occupy a slot.
  assign enq = (p_fire || m_fire) && (in_wa != 5'd0);

  assign RegWrite = (count != '0) && !grf_busy;
  assign deq      = RegWrite;
  assign WA = RegWrite ? wa_q[rd_ptr] : 5'd0;
  assign WD = RegWrite ? wd_q[rd_ptr] : 32'd0;
  assign PC = RegWrite ? pc_q[rd_ptr] : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      wa_q[wr_ptr] <= in_wa;
      wd_q[wr_ptr] <= in_wd;
      pc_q[wr_ptr] <= in_pc;
    end
  end

  // Scans stored entries only, so the head counts while issuing and the incoming write does not.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        if (wa_q[idx] == RA1) pend1 = 1'b1;
        if (wa_q[idx] == RA2) pend2 = 1'b1;
      end
    end
    if (RA1 == 5'd0) pend1 = 1'b0;
    if (RA2 == 5'd0) pend2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: hand-computed expectations for issue order, priority, fill, $0, hazards, reset.
module tb_wb_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid, m_valid, grf_busy;
  logic [4:0]  p_wa, m_wa, RA1, RA2, WA;
  logic [31:0] p_wd, p_pc, m_wd, m_pc, WD, PC;
  logic        p_ready, m_ready, RegWrite, pend1, pend2;

  int n_chk  = 0;
  int n_pass = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_wa(p_wa), .p_wd(p_wd), .p_pc(p_pc), .p_ready(p_ready),
    .m_valid(m_valid), .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc), .m_ready(m_ready),
    .grf_busy(grf_busy), .RegWrite(RegWrite), .WA(WA), .WD(WD), .PC(PC),
    .RA1(RA1), .RA2(RA2), .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pw(input logic v, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    p_valid = v; p_wa = wa; p_wd = wd; p_pc = pc;
  endtask

  initial begin
    reset = 1'b0; grf_busy = 1'b0; RA1 = 5'd0; RA2 = 5'd0;
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    m_valid = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_pc = 32'd0;

    // Reset state
    #2;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wa", WA, 0);
    chk("rst_p_ready", p_ready, 1);
    chk("rst_m_ready", m_ready, 1);
    chk("rst_pend", {pend1, pend2}, 0);
    p_valid = 1'b1; #1;
    chk("rst_m_ready_pvalid", m_ready, 0);
    p_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Single write, one-cycle latency
    pw(1'b1, 5'd5, 32'h1234, 32'h3000);
    #1 chk("single_no_passthru", RegWrite, 0);
    tick();
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    chk("single_regwrite", RegWrite, 1);
    chk("single_wa", WA, 5);
    chk("single_wd", WD, 32'h1234);
    chk("single_pc", PC, 32'h3000);
    tick();
    chk("single_done", RegWrite, 0);
    chk("single_wa_zero", WA, 0);

    // Priority: pipeline beats mult/div until it goes idle
    pw(1'b1, 5'd1, 32'h11, 32'h100);
    m_valid = 1'b1; m_wa = 5'd2; m_wd = 32'hAA; m_pc = 32'h200;
    #1 chk("prio_p_ready", p_ready, 1);
    chk("prio_m_ready0", m_ready, 0);
    tick();
    pw(1'b1, 5'd3, 32'h33, 32'h104);
    #1 chk("prio_m_ready1", m_ready, 0);
    chk("prio_issue1", WA, 1);
    tick();
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    #1 chk("prio_m_ready_idle", m_ready, 1);
    chk("prio_issue3", WA, 3);
    tick();
    m_valid = 1'b0;
    chk("prio_issue2_wa", WA, 2);
    chk("prio_issue2_wd", WD, 32'hAA);
    chk("prio_issue2_pc", PC, 32'h200);
    tick();
    chk("prio_empty", RegWrite, 0);

    // Fill while GRF busy
    grf_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      pw(1'b1, 5'(k), 32'(k * 16), 32'(32'h4000 + k * 4));
      #1 chk($sformatf("fill_p_ready_%0d", k), p_ready, (k <= 4) ? 1 : 0);
      tick();
    end
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    RA1 = 5'd4; RA2 = 5'd5;
    #1 chk("fill_busy_regwrite", RegWrite, 0);
    chk("fill_busy_wa", WA, 0);
    chk("fill_pend_4", pend1, 1);
    chk("fill_pend_5", pend2, 0);
    // Dequeue on the same edge as a full-queue offer must not admit it
    grf_busy = 1'b0;
    pw(1'b1, 5'd6, 32'h66, 32'h600);
    #1 chk("full_deq_p_ready", p_ready, 0);
    chk("drain_1", WA, 1);
    chk("drain_1_wd", WD, 32'h10);
    tick();
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      #1 chk($sformatf("drain_%0d", k), WA, 5'(k));
      chk($sformatf("drain_rw_%0d", k), RegWrite, 1);
      tick();
    end
    chk("drain_no_extra", RegWrite, 0);

    // Writes to $0 are swallowed
    pw(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h500);
    #1 chk("zero_p_ready", p_ready, 1);
    tick();
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    chk("zero_no_issue", RegWrite, 0);
    chk("zero_wd", WD, 0);
    tick();
    chk("zero_no_issue2", RegWrite, 0);

    // Hazard lookup
    grf_busy = 1'b1;
    pw(1'b1, 5'd7, 32'h77, 32'h700);
    tick();
    pw(1'b1, 5'd9, 32'h99, 32'h704);
    RA1 = 5'd9; RA2 = 5'd7;
    #1 chk("haz_excl_incoming", pend1, 0);
    chk("haz_stored_7", pend2, 1);
    tick();
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    RA1 = 5'd7; RA2 = 5'd8;
    #1 chk("haz_pend1", pend1, 1);
    chk("haz_pend2", pend2, 0);
    RA2 = 5'd9;
    #1 chk("haz_pend2_9", pend2, 1);
    grf_busy = 1'b0;
    #1 chk("haz_head_issuing", pend1, 1);
    chk("haz_head_wa", WA, 7);
    tick();
    chk("haz_after_issue", pend1, 0);
    chk("haz_next_wa", WA, 9);
    RA1 = 5'd0;
    #1 chk("haz_ra_zero", pend1, 0);
    tick();
    chk("haz_drained", pend2, 0);

    // Async reset mid-operation
    grf_busy = 1'b1;
    for (int k = 10; k <= 12; k++) begin
      pw(1'b1, 5'(k), 32'(k), 32'h800);
      tick();
    end
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    grf_busy = 1'b0;
    #1 chk("arst_pre_wa", WA, 10);
    reset = 1'b0;
    #1 chk("arst_regwrite_drop", RegWrite, 0);
    chk("arst_p_ready", p_ready, 1);
    #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("arst_no_stale_%0d", k), RegWrite, 0);
    end
    pw(1'b1, 5'd13, 32'hD, 32'h900);
    tick();
    pw(1'b0, 5'd0, 32'd0, 32'd0);
    chk("arst_resume_wa", WA, 13);
    chk("arst_resume_rw", RegWrite, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO entries; a power of two, at least 2.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 p_valid  in  1  the pipeline writeback stage presents a register write.
REQ-005 p_wa / p_wd / p_pc  in  5 / 32 / 32  pipeline destination register, data, instruction PC.
REQ-006 p_ready  out  1  the pipeline write is accepted this cycle.
REQ-007 m_valid  in  1  the mult/div unit presents a register write.
REQ-008 m_wa / m_wd / m_pc  in  5 / 32 / 32  mult/div destination register, data, PC.
REQ-009 m_ready  out  1  the mult/div write is accepted this cycle.
REQ-010 grf_busy  in  1  the GRF write port is unavailable this cycle; no issue.
REQ-011 RegWrite  out  1  GRF write enable.
REQ-012 WA / WD / PC  out  5 / 32 / 32  GRF write address, data, PC.
REQ-013 RA1 / RA2  in  5 / 5  hazard-lookup addresses, the same as the GRF read addresses.
REQ-014 pend1 / pend2  out  1 / 1  a queued, unissued write targets RA1 / RA2.

Function
REQ-015 The queue SHALL hold pending GRF writes {wa, wd, pc} in strict FIFO order, with a count of 0..DEPTH.
REQ-016 The queue SHALL accept at most one write per cycle; a transfer occurs on a rising edge where valid and ready are both high.
REQ-017 The pipeline SHALL have priority: p_ready = (count != DEPTH).
REQ-018 The mult/div port SHALL be ready only when the pipeline is idle: m_ready = (count != DEPTH) && !p_valid.
REQ-019 An accepted write with wa == 0 SHALL be discarded: it is not enqueued and count is unchanged.
REQ-020 The GRF outputs SHALL be combinational from the FIFO head: RegWrite = (count != 0) && !grf_busy; WA/WD/PC = head entry.
REQ-021 When RegWrite is low, WA, WD and PC SHALL be 0.
REQ-022 The head SHALL dequeue on each rising edge where RegWrite = 1.
REQ-023 Enqueue latency SHALL be one cycle: a write accepted at edge N drives RegWrite in the cycle after N if it is at the head and grf_busy is low; there is no same-cycle pass-through.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged, and both pointers SHALL advance.
REQ-025 When full, acceptance SHALL be decided on the pre-edge count, so no write is accepted even if a dequeue occurs on the same edge.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-027 pend1 SHALL be 1 if and only if RA1 != 0 and some occupied entry has wa == RA1; pend2 is the same for RA2.
REQ-028 pend1 / pend2 SHALL be combinational, SHALL include the head entry even while it is issuing, and SHALL exclude the incoming write in the same cycle.
REQ-029 With grf_busy held high, the queue contents SHALL be frozen apart from enqueues.

Reset
REQ-030 While reset = 0, the block SHALL clear count, rd_ptr and wr_ptr to 0, and entry contents are don't-care.
REQ-031 While reset = 0, the block SHALL drive RegWrite = 0, WA = 0, WD = 0, PC = 0, pend1 = pend2 = 0, p_ready = 1 and m_ready = !p_valid.
REQ-032 A reset assertion mid-operation SHALL drop all queued writes without issuing them, and the first rising edge after release SHALL operate normally.

Verification
REQ-033 Single write: p_valid with wa = 5, wd = 0x1234, pc = 0x3000 for one cycle -> the next cycle gives RegWrite = 1, WA = 5, WD = 0x1234, PC = 0x3000, then RegWrite = 0.
REQ-034 Priority: p_valid and m_valid both high for 2 cycles -> p_ready = 1, m_ready = 0, and the m write is accepted only in the first cycle with p_valid low.
REQ-035 Fill: grf_busy = 1 with 5 writes to $1..$5 -> the 4 writes to $1..$4 are accepted and p_ready = 0 on the 5th; releasing grf_busy issues $1..$4 in order on consecutive cycles.
REQ-036 Zero register: a write to $0 with wd = 0xFFFF_FFFF -> it is accepted, RegWrite never asserts for it, and count stays 0.
REQ-037 Hazard lookup: queue holds {$7, $9} and RA1 = 7, RA2 = 8 -> pend1 = 1, pend2 = 0; after $7 issues, pend1 = 0; RA1 = 0 gives pend1 = 0.
REQ-038 Async reset: with 3 entries queued, pulse reset low between edges -> RegWrite drops immediately, and after release no stale write ever issues.
